// File: rtl/prog_loader_pkg.sv
// Shared types and default constants for the boot-time program loader.
// The optional trailing-checksum state exists only when PROG_LOADER_CKSUM_EN is defined.
package prog_loader_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
  localparam int unsigned MAX_WORDS_DEFAULT = 4096;
  localparam int unsigned TIMEOUT_DEFAULT   = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
`ifdef PROG_LOADER_CKSUM_EN
    , ST_CKSUM = 3'd6
`endif
  } prog_loader_state_e;

  // States in which the byte stream is live and the system is held in reset.
  function automatic logic is_loading(prog_loader_state_e s);
    logic r;
    r = (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE);
`ifdef PROG_LOADER_CKSUM_EN
    r = r || (s == ST_CKSUM);
`endif
    return r;
  endfunction

endpackage

// File: rtl/prog_word_asm.sv
// Little-endian 4-byte word assembler with a one-byte holding register that
// absorbs a byte arriving while the completed word is still waiting to be consumed.
module prog_word_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        consume,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        overrun
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [1:0]  slot;

  assign word_valid = cnt_q[2];
  assign word       = word_q;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    word_d      = word_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun     = 1'b0;
    slot        = 2'd0;
    if (clear) begin
      cnt_d       = 3'd0;
      hold_full_d = 1'b0;
    end else if (consume) begin
      // A held byte becomes byte 0 of the next word, any byte arriving now follows it.
      cnt_d       = 3'd0;
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        word_d[7:0] = hold_q;
        slot        = 2'd1;
        cnt_d       = 3'd1;
      end
      if (byte_valid) begin
        word_d[{slot, 3'b000} +: 8] = byte_data;
        cnt_d = {1'b0, slot} + 3'd1;
      end
    end else if (byte_valid) begin
      if (!cnt_q[2]) begin
        word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_data;
        cnt_d = cnt_q + 3'd1;
      end else if (!hold_full_q) begin
        hold_d      = byte_data;
        hold_full_d = 1'b1;
      end else begin
        overrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      word_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed byte image into words, writes
// them to instruction memory and drives the reset manager. Option: PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
  parameter int unsigned MAX_WORDS      = MAX_WORDS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        boot_sel_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  output logic        prog_o,
  output logic        prog_rst_no,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  prog_loader_state_e state_q, state_d;
  logic             boot_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             prog_q, prog_d;
  logic             done_q, done_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [31:0]      xor_q, xor_d;
`endif

  logic        boot_rise, boot_fall;
  logic        rx_active, tmo_active, tmo_hit, last_word;
  logic        asm_clear, asm_consume, asm_valid, asm_overrun;
  logic [31:0] asm_word;

  assign boot_rise  = boot_sel_i & ~boot_q;
  assign boot_fall  = ~boot_sel_i & boot_q;
  assign rx_active  = is_loading(state_q);
  assign tmo_active = rx_active && (state_q != ST_WRITE);
  assign tmo_hit    = tmo_active && !rx_valid_i && (tmo_q == TMO_LAST);
  assign last_word  = (idx_q + IDX_W'(1)) == n_q;

  prog_word_asm u_word_asm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear      (asm_clear),
    .byte_valid (rx_valid_i && rx_active),
    .byte_data  (rx_data_i),
    .consume    (asm_consume),
    .word_valid (asm_valid),
    .word       (asm_word),
    .overrun    (asm_overrun)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    tmo_d       = tmo_q;
    prog_d      = 1'b0;
    done_d      = done_q;
    asm_clear   = 1'b0;
    asm_consume = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    xor_d       = xor_q;
`endif
    // Idle-gap counter: frozen while a write is outstanding, cleared by any byte.
    if (tmo_active) tmo_d = rx_valid_i ? '0 : tmo_q + TMO_W'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (boot_rise) begin
          state_d   = ST_LEN;
          prog_d    = 1'b1;
          done_d    = 1'b0;
          asm_clear = 1'b1;
          idx_d     = '0;
          tmo_d     = '0;
`ifdef PROG_LOADER_CKSUM_EN
          xor_d     = '0;
`endif
        end else if (state_q == ST_DONE && boot_fall) begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (asm_valid) begin
          asm_consume = 1'b1;
          if (asm_word == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (asm_word > 32'(MAX_WORDS)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
            n_d     = asm_word[IDX_W-1:0];
            idx_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (asm_overrun || (!asm_valid && tmo_hit)) state_d = ST_ERROR;
        else if (asm_valid)                         state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (asm_overrun) begin
          state_d = ST_ERROR;
        end else if (mem_gnt_i) begin
          asm_consume = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
`ifdef PROG_LOADER_CKSUM_EN
          xor_d       = xor_q ^ asm_word;
          state_d     = last_word ? ST_CKSUM : ST_DATA;
`else
          state_d     = last_word ? ST_DONE : ST_DATA;
          done_d      = last_word;
`endif
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (asm_overrun) begin
          state_d = ST_ERROR;
        end else if (asm_valid) begin
          asm_consume = 1'b1;
          if (asm_word == xor_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
        end
      end
`endif
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      boot_q  <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      tmo_q   <= '0;
      prog_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      boot_q  <= boot_sel_i;
      idx_q   <= idx_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      prog_q  <= prog_d;
      done_q  <= done_d;
`ifdef PROG_LOADER_CKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign mem_req_o   = (state_q == ST_WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = BASE_ADDR + (32'(idx_q) << 2);
  assign mem_wdata_o = asm_word;
  assign prog_o      = prog_q;
  assign prog_rst_no = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done_o      = done_q;
  assign err_o       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed boundary cases plus randomized images
// checked against an image-level model of the expected memory writes and outcome.
module tb_prog_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_0100;
  localparam int          TB_MAX  = 4096;
  localparam int          TB_TMO  = 100;

  logic        clk_i, rst_ni, boot_sel_i, rx_valid_i, mem_gnt_i;
  logic [7:0]  rx_data_i;
  logic        mem_req_o, mem_we_o, prog_o, prog_rst_no, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  prog_loader #(
    .BASE_ADDR      (TB_BASE),
    .MAX_WORDS      (TB_MAX),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .boot_sel_i  (boot_sel_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .prog_o      (prog_o),
    .prog_rst_no (prog_rst_no),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  req_cycles = 0;
  int  gnt_mode   = 0;  // 0: tied high, 1: random latency up to 3 cycles, 2: held low

  // Write monitor: logs granted writes and checks address/data hold while waiting.
  initial begin
    logic        pend;
    logic [31:0] pa, pd;
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni || !mem_req_o) begin
        pend = 1'b0;
      end else begin
        req_cycles++;
        check("we_follows_req", mem_we_o, 1'b1);
        if (pend) begin
          check("addr_stable", mem_addr_o, pa);
          check("data_stable", mem_wdata_o, pd);
        end
        if (mem_gnt_i) begin
          wr_q.push_back('{mem_addr_o, mem_wdata_o});
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pa   = mem_addr_o;
          pd   = mem_wdata_o;
        end
      end
    end
  end

  // Memory responder.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_gnt_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (gnt_mode == 0)      mem_gnt_i = 1'b1;
      else if (gnt_mode == 2) mem_gnt_i = 1'b0;
      else if (mem_req_o)     mem_gnt_i = (wait_cnt >= 3) || ($urandom_range(0, 1) == 1);
      else                    mem_gnt_i = 1'($urandom_range(0, 1));
      wait_cnt = mem_req_o ? wait_cnt + 1 : 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  // Gaps before the second byte of each word exceed the worst grant latency,
  // so at most one byte ever waits in the holding register.
  task automatic send_stream(input logic [7:0] s[$], input int drop_at);
    for (int k = 0; k < s.size(); k++) begin
      idle((k % 4 == 1) ? $urandom_range(4, 9) : $urandom_range(0, 5));
      if (k == drop_at) boot_sel_i = 1'b0;
      send_byte(s[k]);
    end
  endtask

  task automatic wait_end();
    for (int c = 0; c < 200; c++) begin
      if (done_o || err_o) break;
      idle(1);
    end
    check("end_reached", 32'(done_o | err_o), 32'd1);
  endtask

  task automatic start_load();
    boot_sel_i = 1'b0;
    idle(1);
    boot_sel_i = 1'b1;
    idle(1);
    check("prog_pulse", prog_o, 1'b1);
    check("prog_rst_low", prog_rst_no, 1'b0);
    check("done_cleared", done_o, 1'b0);
    idle(1);
    check("prog_one_cycle", prog_o, 1'b0);
    check("prog_rst_held", prog_rst_no, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, TB_BASE);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_prog", prog_o, 1'b0);
    check("rst_prog_rst_n", prog_rst_no, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
  endtask

  task automatic do_reset();
    boot_sel_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    check_reset_state();
    idle(2);
    rst_ni = 1'b1;
    idle(1);
  endtask

  task automatic check_writes(input logic [31:0] words[$]);
    check("write_count", wr_q.size(), words.size());
    for (int i = 0; i < words.size() && i < wr_q.size(); i++) begin
      check("write_addr", wr_q[i].addr, TB_BASE + 32'(4 * i));
      check("write_data", wr_q[i].data, words[i]);
    end
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w[$];
    int          rc;

    rst_ni     = 1'b0;
    boot_sel_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    #1;
    check_reset_state();
    idle(2);
    rst_ni = 1'b1;
    idle(1);
    check_reset_state();

    // Two-word image with grant tied high.
    gnt_mode = 0;
    wr_q.delete();
    start_load();
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stream(s, -1);
    wait_end();
    check("t1_done", done_o, 1'b1);
    check("t1_err", err_o, 1'b0);
    check("t1_prog_rst_n", prog_rst_no, 1'b1);
    w = '{32'h0000_0013, 32'h0000_006F};
    check_writes(w);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      check("held_level_no_retrigger", prog_o, 1'b0);
    end
    boot_sel_i = 1'b0;
    idle(2);
    check("done_persists_idle", done_o, 1'b1);
    check("idle_prog_rst_n", prog_rst_no, 1'b1);

    // Zero-length image.
    wr_q.delete();
    rc = req_cycles;
    start_load();
    send_word(32'd0);
    idle(1);
    check("zero_done", done_o, 1'b1);
    check("zero_prog_rst_n", prog_rst_no, 1'b1);
    check("zero_no_req", req_cycles, rc);

    // Length one beyond the limit; error is sticky.
    start_load();
    send_word(32'(TB_MAX + 1));
    idle(1);
    check("len_err", err_o, 1'b1);
    check("len_err_rst_n", prog_rst_no, 1'b0);
    for (int c = 0; c < 6; c++) begin
      boot_sel_i = ~boot_sel_i;
      idle(1);
      check("err_no_prog", prog_o, 1'b0);
      check("err_sticky", err_o, 1'b1);
    end
    do_reset();

    // Overrun while a write waits for grant.
    gnt_mode = 2;
    start_load();
    send_word(32'd1);
    send_word(32'hDDCC_BBAA);
    for (int c = 0; c < 10 && !mem_req_o; c++) idle(1);
    check("ovr_req", mem_req_o, 1'b1);
    check("ovr_addr", mem_addr_o, TB_BASE);
    check("ovr_data", mem_wdata_o, 32'hDDCC_BBAA);
    idle(3);
    send_byte(8'h11);
    check("ovr_hold_ok", err_o, 1'b0);
    idle(2);
    check("ovr_addr_wait", mem_addr_o, TB_BASE);
    check("ovr_data_wait", mem_wdata_o, 32'hDDCC_BBAA);
    send_byte(8'h22);
    check("ovr_err", err_o, 1'b1);
    check("ovr_req_dropped", mem_req_o, 1'b0);
    check("ovr_prog_rst_n", prog_rst_no, 1'b0);
    do_reset();

    // Inter-byte timeout.
    gnt_mode = 0;
    start_load();
    send_word(32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(TB_TMO - 2);
    check("tmo_not_yet", err_o, 1'b0);
    send_byte(8'h03);
    idle(TB_TMO - 1);
    check("tmo_before_limit", err_o, 1'b0);
    idle(1);
    check("tmo_at_limit", err_o, 1'b1);
    do_reset();

    // Largest legal length is accepted; asynchronous reset mid-load clears everything.
    start_load();
    send_word(32'(TB_MAX));
    idle(3);
    check("max_len_ok", err_o, 1'b0);
    check("max_len_loading", prog_rst_no, 1'b0);
    do_reset();

`ifdef PROG_LOADER_CKSUM_EN
    start_load();
    send_word(32'd2);
    send_word(32'h13);
    send_word(32'h6F);
    send_word(32'h7C);
    idle(2);
    check("cksum_ok_done", done_o, 1'b1);
    check("cksum_ok_err", err_o, 1'b0);
    start_load();
    send_word(32'd2);
    send_word(32'h13);
    send_word(32'h6F);
    send_word(32'h7D);
    idle(2);
    check("cksum_bad_err", err_o, 1'b1);
    check("cksum_bad_done", done_o, 1'b0);
    do_reset();
`endif

    // Randomized images.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] n, x;
      bit          exp_err;
      n = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       n = 32'(TB_MAX + 1);
          1:       n = 32'h0001_0002;
          default: n = 32'hFFFF_FFFF;
        endcase
      end
      exp_err = (n > 32'(TB_MAX));
      s.delete();
      w.delete();
      for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
      x = '0;
      if (!exp_err) begin
        for (int i = 0; i < int'(n); i++) begin
          logic [31:0] d;
          d = $urandom;
          w.push_back(d);
          x ^= d;
          for (int b = 0; b < 4; b++) s.push_back(d[8*b +: 8]);
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      if (!exp_err && n != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          x ^= 32'(1) << $urandom_range(0, 31);
          exp_err = 1'b1;
        end
        for (int b = 0; b < 4; b++) s.push_back(x[8*b +: 8]);
      end
`endif
      gnt_mode = $urandom_range(0, 1);
      wr_q.delete();
      start_load();
      send_stream(s, $urandom_range(0, s.size()));
      wait_end();
      check("rand_done", done_o, 32'(!exp_err));
      check("rand_err", err_o, 32'(exp_err));
      check("rand_prog_rst_n", prog_rst_no, 32'(!exp_err));
      check_writes(w);
      if (exp_err) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
